// File: rtl/pipe_pkg.sv
// Shared types for elastic pipeline-stage registers.
package pipe_pkg;

    // Occupancy of a pipeline-stage register; encoding doubles as the entry count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // EX/MEM control bundle carried in the ctrl field.
    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } ex_mem_ctrl_t;

    // EX/MEM data bundle for users that pack the full stage payload into the data field.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic [2:0]  funct3;
    } ex_mem_data_t;

    localparam int unsigned EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int unsigned EX_MEM_DATA_W = $bits(ex_mem_data_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CntMax = {W{1'b1}};
    localparam logic [W-1:0] CntOne = {{(W-1){1'b0}}, 1'b1};

    // Count up on inc, sticking at the all-ones value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != CntMax)) begin
            count <= count + CntOne;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with optional 2-entry skid buffer and stall counter.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_xfer, out_xfer;
    logic              load_main_in, load_main_skid, load_skid;

    assign out_valid = (state_q != OCC_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Next occupancy and entry-load strobes; flush overrides everything and drops any in beat.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        state_d      = OCC_ONE;
                        load_main_in = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (in_xfer && (SKID != 0)) begin
                        state_d   = OCC_TWO;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (out_xfer) begin
                        state_d        = OCC_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    // Occupancy state and head entry; data is kept across bubbles, only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OCC_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_data_q <= in_data;
                main_ctrl_q <= in_ctrl;
            end else if (load_main_skid) begin
                main_data_q <= skid_data;
                main_ctrl_q <= skid_ctrl;
            end
        end
    end

    if (SKID != 0) begin : g_skid
        logic [DATA_W-1:0] skid_data_q;
        logic [CTRL_W-1:0] skid_ctrl_q;
        logic              in_ready_q;

        // Skid entry and registered ready, so upstream never sees out_ready combinationally.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                skid_data_q <= '0;
                skid_ctrl_q <= '0;
                in_ready_q  <= 1'b1;
            end else begin
                in_ready_q <= (state_d != OCC_TWO);
                if (load_skid) begin
                    skid_data_q <= in_data;
                    skid_ctrl_q <= in_ctrl;
                end
            end
        end

        assign skid_data = skid_data_q;
        assign skid_ctrl = skid_ctrl_q;
        assign in_ready  = in_ready_q;
    end else begin : g_no_skid
        logic unused_load_skid;

        assign unused_load_skid = load_skid;
        assign skid_data        = '0;
        assign skid_ctrl        = '0;
        // Single entry: can take a beat when empty or when the head leaves this cycle.
        assign in_ready         = (state_q == OCC_EMPTY) | out_ready;
    end

    // Bubbles must never carry live control into later stages.
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign occupancy = state_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_valid & ~out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: skid variant (u_a) and single-entry variant (u_b).
module tb_pipe_skid_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [3:0]  a_in_ctrl, a_out_ctrl;
    logic [1:0]  a_occ;
    logic [15:0] a_stall;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [3:0]  b_in_ctrl, b_out_ctrl;
    logic [1:0]  b_occ;
    logic [3:0]  b_stall;

    pipe_skid_reg #(.DATA_W(32), .CTRL_W(4), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_ctrl(a_out_ctrl), .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_skid_reg #(.DATA_W(32), .CTRL_W(4), .SKID(0), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ctrl(b_out_ctrl), .occupancy(b_occ), .stall_cnt(b_stall)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  ctrl;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [31:0] d, input logic [3:0] c, input bit push);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_ctrl  = c;
        if (push) exp_q.push_back('{data: d, ctrl: c});
    endtask

    // Monitor: pop the expected beat whenever u_a completes an output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (!a_out_valid) begin
                check("a_bubble_ctrl", {60'd0, a_out_ctrl}, 64'd0);
            end else if (a_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected_beat actual=%0h required=none", a_out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("a_data", {32'd0, a_out_data}, {32'd0, mon_e.data});
                    check("a_ctrl", {60'd0, a_out_ctrl}, {60'd0, mon_e.ctrl});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_flush = 0; a_in_valid = 0; a_in_data = 0; a_in_ctrl = 0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_data = 0; b_in_ctrl = 0; b_out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_occ", a_occ, 0);
        check("rst_stall", a_stall, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_b_in_ready", b_in_ready, 1);

        // T2 stream: one beat per cycle, one cycle latency
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_a(32'h10 + i, 4'(i + 1), 1'b1);
            step();
            check("t2_out_valid", a_out_valid, 1);
            check("t2_out_data", a_out_data, 32'h10 + i);
        end
        a_in_valid = 1'b0;
        step();
        check("t2_occ_drained", a_occ, 0);

        // T3 backpressure fills the skid, C held upstream
        a_out_ready = 1'b0;
        send_a(32'hA, 4'h5, 1'b1);
        step();
        send_a(32'hB, 4'h6, 1'b1);
        step();
        send_a(32'hC, 4'h7, 1'b0);
        check("t3_occ_full", a_occ, 2);
        check("t3_in_ready_low", a_in_ready, 0);
        step();
        step();
        step();
        check("t3_occ_hold", a_occ, 2);
        check("t3_stall", a_stall, 4);
        exp_q.push_back('{data: 32'hC, ctrl: 4'h7});
        a_out_ready = 1'b1;
        step();
        check("t3_in_ready_back", a_in_ready, 1);
        check("t3_head_b", a_out_data, 32'hB);
        step();
        check("t3_head_c", a_out_data, 32'hC);
        a_in_valid = 1'b0;
        step();
        check("t3_occ_drained", a_occ, 0);
        check("t3_stall_after", a_stall, 4);
        check("t3_queue_empty", exp_q.size(), 0);

        // T4 flush from full; 0xD offered during flush
        a_out_ready = 1'b0;
        send_a(32'h1, 4'h3, 1'b1);
        step();
        send_a(32'h2, 4'h4, 1'b1);
        step();
        check("t4_occ_full", a_occ, 2);
        a_flush = 1'b1;
        send_a(32'hD, 4'hF, 1'b0);
        exp_q.delete();
        step();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        check("t4_out_valid", a_out_valid, 0);
        check("t4_out_ctrl", a_out_ctrl, 0);
        check("t4_occ", a_occ, 0);
        check("t4_in_ready", a_in_ready, 1);
        check("t4_stall", a_stall, 6);

        // Flush while in_ready=1: the accepted 0xE must be discarded
        send_a(32'h3, 4'h2, 1'b1);
        step();
        a_flush = 1'b1;
        send_a(32'hE, 4'hF, 1'b0);
        exp_q.delete();
        step();
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        repeat (3) step();
        check("t4b_occ", a_occ, 0);
        check("t4b_stall", a_stall, 7);

        // T1 reset pulse with a beat in flight
        a_out_ready = 1'b0;
        send_a(32'h77, 4'h8, 1'b1);
        step();
        a_in_valid = 1'b0;
        step();
        check("t1_stall_pre", a_stall, 8);
        #2 rst = 1'b1;
        #1;
        check("t1_out_valid", a_out_valid, 0);
        check("t1_out_ctrl", a_out_ctrl, 0);
        check("t1_occ", a_occ, 0);
        check("t1_stall", a_stall, 0);
        check("t1_in_ready", a_in_ready, 1);
        exp_q.delete();
        #2 rst = 1'b0;
        step();
        check("t1_out_valid_after", a_out_valid, 0);

        // T5 single entry: in_ready follows out_ready combinationally
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        b_in_data = 32'h55;
        b_in_ctrl = 4'h9;
        step();
        b_in_valid = 1'b0;
        check("t5_in_ready_full", b_in_ready, 0);
        check("t5_data", b_out_data, 32'h55);
        check("t5_ctrl", b_out_ctrl, 4'h9);
        b_out_ready = 1'b1;
        #1 check("t5_in_ready_comb_hi", b_in_ready, 1);
        b_out_ready = 1'b0;
        #1 check("t5_in_ready_comb_lo", b_in_ready, 0);

        // T6 saturation at 15 on the 4-bit counter
        repeat (14) step();
        check("t6_stall_14", b_stall, 14);
        repeat (6) step();
        check("t6_stall_sat", b_stall, 15);
        b_out_ready = 1'b1;
        step();
        check("t6_occ_drained", b_occ, 0);
        check("t6_stall_kept", b_stall, 15);

        // Single entry passes back-to-back beats without a bubble
        b_in_valid = 1'b1;
        b_in_data = 32'h66;
        step();
        b_in_data = 32'h67;
        check("b_zb_in_ready", b_in_ready, 1);
        step();
        b_in_valid = 1'b0;
        check("b_zb_data", b_out_data, 32'h67);
        check("b_zb_occ", b_occ, 1);
        step();
        check("b_zb_drained", b_occ, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
